rom_stream_reader: RTL and testbench
====================================

# rom_stream_reader

Sequencer that sits directly upstream and downstream of the synchronous ROM. It drives the ROM address for a commanded burst, absorbs the ROM's one-cycle read latency, and presents the returned words as a valid/ready stream with full backpressure support. A 2-entry output buffer and credit-based read issue give one word per cycle when the consumer is always ready, and no data loss when it stalls.

## Interface
- DATA_WIDTH, 8, ROM word width
- ADDR_WIDTH, 4, ROM address width; ROM depth is 2^ADDR_WIDTH
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  burst command strobe; sampled only in IDLE
- start_addr  in  ADDR_WIDTH  first ROM address of the burst
- count  in  ADDR_WIDTH+1  number of words in the burst (0 allowed)
- busy  out  1  high while state is not IDLE
- done  out  1  one-cycle pulse when a burst completes
- rom_addr  out  ADDR_WIDTH  registered address to ROM
- rom_dout  in  DATA_WIDTH  ROM read data, valid one cycle after rom_addr
- m_data  out  DATA_WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from consumer
- m_last  out  1  marks the final word of the burst

## Operation
- States:
  - IDLE: start=1 latches count into remaining, loads rom_addr<=start_addr, goes to RUN. If count=0, goes directly to DONE instead.
  - RUN: issues reads while remaining>0. When the last read is issued, goes to DRAIN.
  - DRAIN: waits until the pending read has landed and the buffer is empty (last beat accepted), then goes to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
- Start is ignored while not in IDLE.
- Issue rule (RUN): issue in a cycle iff remaining>0 and (occupancy + pending − pop) < 2.
  - occupancy: buffer entries held, 0..2.
  - pending: 1 if a read was issued in the previous cycle.
  - pop: m_valid & m_ready this cycle.
- On issue:
  - ROM samples rom_addr at the end of this cycle.
  - rom_addr <= rom_addr+1, wrapping modulo 2^ADDR_WIDTH (bursts longer than the depth re-read from address 0 onward).
  - remaining <= remaining−1.
  - pending <= 1.
- When pending=1, rom_dout is written into the buffer at the end of the cycle.
- The issue rule guarantees the buffer never overflows. A write to a full buffer is a design error; flag it with an assertion.
- Buffer is a 2-entry FIFO with simultaneous push/pop allowed.
- m_data/m_valid are driven from the head entry.
- m_last is a per-entry tag: set on the word fetched when remaining was 1 at issue.
- Stream rules:
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - m_valid is never withdrawn without a handshake.
- rom_addr holds its last value when not issuing.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE.
  - busy=0, done=0, m_valid=0, m_last=0, m_data=0, rom_addr=0.
  - Buffer emptied, pending=0, remaining=0.
- Reset mid-burst aborts it: no done pulse, buffered words discarded.
- Start latency: start sampled at edge E0. rom_addr=start_addr during cycle 1 (first issue). Word captured at E2. m_valid=1 from cycle 3 onward.
- Throughput: with m_ready held 1, one beat per cycle; an N-word burst delivers beats in cycles 3..N+2.
- done is high in the cycle after the edge where the m_last beat is accepted.
- busy is 0 in that same cycle (state=DONE counts as not busy). A start in the DONE cycle is ignored; the earliest new start is the following IDLE cycle.
- count=0: busy=1 for no cycles. done is high in cycle 1 (the cycle after E0). No beats. rom_addr is still loaded with start_addr.
- Backpressure: if m_ready=0 for K cycles, at most 2 words are buffered. Issue stalls, and resumes the cycle pop is asserted.
- Max count = 2^(ADDR_WIDTH+1)−1.

## Test plan
- Reset, start_addr=0, count=8, m_ready=1 (with an attached ROM holding the default pattern 00,11,…,77,FF…) -> beats 00,11,…,77 in cycles 3..10, m_last on 77, done in cycle 11.
- start_addr=14, count=4, m_ready=1 -> rom_addr 14,15,0,1; beats FF,FF,00,11; m_last on the 4th beat.
- count=8, m_ready toggled randomly, including a 5-cycle stall -> exact ordered sequence, no drops or duplicates, data stable while stalled, buffer never exceeds 2 entries.
- count=0 -> no m_valid, done pulse in cycle 1, busy stays 0.
- start pulsed again mid-burst -> ignored; only the original 8 beats are delivered, one done.
- rst_n low mid-burst after 3 beats -> all outputs 0 immediately; a fresh start then gives a correct full burst from its start_addr.

Source files
------------

// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream carrying ROM read data out of rom_stream_reader.
//   m_data  : stream word
//   m_valid : word present on m_data
//   m_ready : consumer accepts the word this cycle
//   m_last  : final word of the burst
interface rom_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/rom_stream_reader.sv
// Burst sequencer in front of a synchronous (1-cycle latency) ROM. Issues
// addresses for a commanded burst and returns the words as a valid/ready
// stream through a 2-entry buffer, using credit-based issue so the buffer
// can never overflow under backpressure.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : burst command, sampled only in IDLE
//   start_addr  : first ROM address of the burst
//   count       : burst length in words (0 allowed)
//   busy        : burst in progress (RUN or DRAIN)
//   done        : one-cycle pulse when the burst completes
//   rom_addr    : registered ROM address
//   rom_dout    : ROM data, valid one cycle after rom_addr
//   m           : output word stream (master side)
module rom_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  rom_stream_reader_if.master   m
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic                  pending_q;
  logic                  pending_last_q;
  entry_t                head_q, head_d;
  entry_t                tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  valid_q;

  logic                  load;
  logic                  issue;
  logic                  pop;
  logic                  push;
  logic                  room;
  logic [2:0]            in_flight;
  entry_t                new_entry;

  // Credit check: words buffered plus the one in flight, less this cycle's pop.
  assign pop       = valid_q & m.m_ready;
  assign push      = pending_q;
  assign in_flight = 3'(occ_q) + 3'(pending_q);
  assign room      = in_flight < (3'd2 + 3'(pop));
  assign new_entry = '{last: pending_last_q, data: rom_dout};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and issue decision
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (remaining_q != '0 && room) begin
          issue = 1'b1;
          if (remaining_q == CNT_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Finish once the last read has landed and its beat is accepted.
        if (!pending_q && (occ_q == 2'd0 || (occ_q == 2'd1 && pop))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst address/length tracking and the one-deep read pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q    <= '0;
      rom_addr       <= '0;
      pending_q      <= 1'b0;
      pending_last_q <= 1'b0;
    end else begin
      if (load) begin
        remaining_q <= count;
        rom_addr    <= start_addr;
      end else if (issue) begin
        remaining_q <= remaining_q - CNT_WIDTH'(1);
        rom_addr    <= rom_addr + ADDR_WIDTH'(1);
      end
      pending_q      <= issue;
      pending_last_q <= issue && (remaining_q == CNT_WIDTH'(1));
    end
  end

  // 2-entry shift FIFO; head is always the presented word
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (pop) begin
      if (occ_q == 2'd2) head_d = tail_q;
      else               head_d.last = 1'b0;
      occ_d = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) head_d = new_entry;
      else               tail_d = new_entry;
      if (occ_d != 2'd2) occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= (occ_d != 2'd0);
    end
  end

  // Status outputs; DONE is deliberately not busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == RUN) || (state_d == DRAIN);
      done <= (state_d == DONE);
    end
  end

  assign m.m_data  = head_q.data;
  assign m.m_last  = head_q.last;
  assign m.m_valid = valid_q;

  // The issue rule keeps at most one word in flight beyond the buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && occ_q == 2'd2));

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;

  localparam int BUDGET = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] start_addr = '0;
  logic [4:0] count = '0;
  logic       busy;
  logic       done;
  logic [3:0] rom_addr;
  logic [7:0] rom_dout;

  int tests = 0;
  int fails = 0;

  rom_stream_reader_if #(.DATA_WIDTH(8)) s_if ();

  rom_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .m          (s_if)
  );

  always #5 clk = ~clk;

  // Attached ROM: 00,11,...,77 then FF for the upper half
  function automatic logic [7:0] rom_word(input logic [3:0] a);
    logic [7:0] w;
    w = 8'(a) * 8'h11;
    return (a < 4'd8) ? w : 8'hFF;
  endfunction

  always_ff @(posedge clk) rom_dout <= rom_word(rom_addr);

  typedef struct {
    logic [3:0]  saddr;
    logic [4:0]  cnt;
    logic [31:0] rdy;      // m_ready per cycle index (1 beyond bit 31)
    int          restart;  // cycle to pulse a second start, -1 none
    int          n;        // expected beats
    logic [63:0] exp;      // beat i in bits [8i+7:8i]
    int          done_cyc; // expected done cycle, -1 unchecked
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int         beats;
    int         done_cyc;
    int         first_cyc;
    int         dones;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic       rdy;
    logic       all_rdy;
    beats = 0; done_cyc = -1; first_cyc = -1; dones = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    all_rdy = (v.rdy == 32'hFFFF_FFFF);
    @(negedge clk);
    start = 1'b1; start_addr = v.saddr; count = v.cnt; s_if.m_ready = v.rdy[0];
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        check("busy_c1", busy, v.cnt != 0);
        check("rom_addr_c1", rom_addr, v.saddr);
      end
      if (all_rdy && c >= 2 && c <= int'(v.cnt))
        check("rom_addr_seq", rom_addr, 4'(v.saddr + 4'(c - 1)));
      if (prev_stall) begin
        check("hold_valid", s_if.m_valid, 1'b1);
        check("hold_data", s_if.m_data, prev_data);
        check("hold_last", s_if.m_last, prev_last);
      end
      if (done) begin
        dones++;
        if (dones == 1) begin
          done_cyc = c;
          check("busy_at_done", busy, 1'b0);
          check("valid_at_done", s_if.m_valid, 1'b0);
          check("beats_at_done", beats, v.n);
        end
      end else if (dones == 0 && v.cnt != 0) begin
        check("busy_in_burst", busy, 1'b1);
      end
      if (done_cyc > 0 && c > done_cyc) begin
        check("busy_after", busy, 1'b0);
        check("valid_after", s_if.m_valid, 1'b0);
      end
      if (s_if.m_valid && first_cyc < 0) first_cyc = c;
      rdy = (c < 32) ? v.rdy[c] : 1'b1;
      if (c == v.restart) begin
        start = 1'b1; start_addr = 4'd9; count = 5'd3;
      end
      s_if.m_ready = rdy;
      if (s_if.m_valid && rdy) begin
        if (beats < v.n) begin
          check("beat_data", s_if.m_data, v.exp[8*beats +: 8]);
          check("beat_last", s_if.m_last, beats == v.n - 1);
        end else begin
          check("extra_beat", beats, v.n);
        end
        beats++;
      end
      prev_stall = s_if.m_valid && !rdy;
      prev_data  = s_if.m_data;
      prev_last  = s_if.m_last;
      if (done_cyc > 0 && c >= done_cyc + 3) break;
    end
    if (done_cyc < 0) check("done_timeout", 0, 1);
    else if (v.done_cyc >= 0) check("done_cycle", done_cyc, v.done_cyc);
    check("done_count", dones, 1);
    check("beat_count", beats, v.n);
    if (v.n == 0) check("no_valid", first_cyc, -1);
    else          check("first_beat_cyc", first_cyc, 3);
    s_if.m_ready = 1'b1;
  endtask

  initial begin
    s_if.m_ready = 1'b1;
    vecs[0] = '{4'd0,  5'd8, 32'hFFFF_FFFF, -1, 8, 64'h7766_5544_3322_1100, 11};
    vecs[1] = '{4'd14, 5'd4, 32'hFFFF_FFFF, -1, 4, 64'h0000_0000_1100_FFFF, 7};
    vecs[2] = '{4'd0,  5'd8, 32'hFFFF_DA0F, -1, 8, 64'h7766_5544_3322_1100, -1};
    vecs[3] = '{4'd3,  5'd0, 32'hFFFF_FFFF, -1, 0, 64'h0,                    1};
    vecs[4] = '{4'd0,  5'd8, 32'hFFFF_FFFF,  4, 8, 64'h7766_5544_3322_1100, 11};
    vecs[5] = '{4'd4,  5'd5, 32'hFFFF_FFFF,  8, 5, 64'h0000_00FF_7766_5544, 8};
    vecs[6] = '{4'd6,  5'd3, 32'hFFFF_FFC7, -1, 3, 64'h0000_0000_00FF_7766, 9};
    vecs[7] = '{4'd2,  5'd8, 32'hFFFF_FFFF, -1, 8, 64'hFFFF_7766_5544_3322, 11};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", s_if.m_valid, 1'b0);
    check("rst_last", s_if.m_last, 1'b0);
    check("rst_data", s_if.m_data, 8'h00);
    check("rst_addr", rom_addr, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_burst(vecs[i]);

    // Asynchronous reset after three beats have been accepted
    @(negedge clk);
    start = 1'b1; start_addr = 4'd2; count = 5'd8; s_if.m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_valid", s_if.m_valid, 1'b1);
    check("pre_rst_data", s_if.m_data, 8'h55);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_valid", s_if.m_valid, 1'b0);
    check("mid_rst_last", s_if.m_last, 1'b0);
    check("mid_rst_data", s_if.m_data, 8'h00);
    check("mid_rst_addr", rom_addr, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_valid", s_if.m_valid, 1'b0);
    check("post_rst_done", done, 1'b0);
    run_burst(vecs[7]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
